// File: rtl/mux_tree_pkg.sv
// rtl/mux_tree_pkg.sv - shared defaults and helpers for the pipelined mux tree
//
// Purpose : default channel width / channel count and the clog2 helper used
//           to derive the select width (and tree depth) from NUM_IN.
// Ports   : none (package).

package mux_tree_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_NUM_IN = 16;

   // Ceiling log2; NUM_IN is a power of two so this is the exact depth.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_level.sv
// rtl/mux_level.sv - one registered 2:1 selection level of the mux tree
//
// Purpose : halves the word count using select bit 0 of the incoming select,
//           registers the surviving words, the remaining select bits and the
//           valid bit. All registers hold while hold=1.
// Ports   : clk        clock, rising edge
//           rst_n      asynchronous active-low reset, clears every register
//           hold       1 = keep contents (downstream stall)
//           src_valid  valid bit from the previous level (or the input port)
//           src_sel    select bits still to be consumed; bit 0 used here
//           src_words  2*WORDS packed words from the previous level
//           valid      registered valid bit
//           sel        registered select bits [SEL_IN_W-1:1] (0 at last level)
//           words      WORDS registered packed words

module mux_level #(
   parameter int WORDS     = 1,
   parameter int DATA_W    = 8,
   parameter int SEL_IN_W  = 1,
   localparam int SEL_OUT_W = (SEL_IN_W > 1) ? SEL_IN_W - 1 : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        hold,
   input  logic                        src_valid,
   input  logic [SEL_IN_W-1:0]         src_sel,
   input  logic [2*WORDS*DATA_W-1:0]   src_words,
   output logic                        valid,
   output logic [SEL_OUT_W-1:0]        sel,
   output logic [WORDS*DATA_W-1:0]     words
);

   logic [WORDS*DATA_W-1:0] next_words;
   logic [SEL_OUT_W-1:0]    next_sel;

   always_comb begin
      next_words = '0;
      for (int j = 0; j < WORDS; j++) begin
         next_words[j*DATA_W +: DATA_W] = src_sel[0] ? src_words[(2*j+1)*DATA_W +: DATA_W]
                                                     : src_words[(2*j)*DATA_W +: DATA_W];
      end
   end

   // The last level has no select bits left to carry; a constant 0 keeps
   // the port at a legal one-bit width.
   if (SEL_IN_W > 1) begin : g_carry
      assign next_sel = src_sel[SEL_IN_W-1:1];
   end else begin : g_carry
      assign next_sel = '0;
   end

   // Data and select load even for bubbles; only the valid bit matters then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         sel   <= '0;
         words <= '0;
      end else if (!hold) begin
         valid <= src_valid;
         sel   <= next_sel;
         words <= next_words;
      end
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined NUM_IN:1 mux tree with valid/ready flow control
//
// Purpose : selects channel in_sel of in_data through SEL_W registered 2:1
//           levels (LSB of the select consumed first). Latency SEL_W cycles,
//           one transfer per cycle, whole pipe freezes on an output stall.
// Ports   : clk        clock, rising edge
//           rst_n      asynchronous active-low reset
//           in_data    NUM_IN packed channels, channel i at [i*DATA_W +: DATA_W]
//           in_sel     channel index
//           in_valid   in_data/in_sel valid
//           in_ready   transfer accepted this cycle (= not stalled)
//           out_data   selected channel
//           out_valid  out_data holds a result
//           out_ready  downstream accepts out_data

module mux_tree_pipe
   import mux_tree_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NUM_IN = DEF_NUM_IN,
   localparam int SEL_W = clog2(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_IN*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);

   // Only a valid word at the output can stall; bubbles never block.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
      localparam int W_IN  = NUM_IN >> k;
      localparam int W_OUT = NUM_IN >> (k + 1);
      localparam int S_IN  = SEL_W - k;
      localparam int S_OUT = (S_IN > 1) ? S_IN - 1 : 1;

      logic [W_IN*DATA_W-1:0]  src_words;
      logic [S_IN-1:0]         src_sel;
      logic                    src_valid;
      logic [W_OUT*DATA_W-1:0] words;
      logic [S_OUT-1:0]        sel;
      logic                    valid;

      if (k == 0) begin : g_src
         assign src_words = in_data;
         assign src_sel   = in_sel;
         assign src_valid = in_valid;
      end else begin : g_src
         assign src_words = g_lvl[k-1].words;
         assign src_sel   = g_lvl[k-1].sel;
         assign src_valid = g_lvl[k-1].valid;
      end

      mux_level #(
         .WORDS    (W_OUT),
         .DATA_W   (DATA_W),
         .SEL_IN_W (S_IN)
      ) u_level (
         .clk       (clk),
         .rst_n     (rst_n),
         .hold      (stall),
         .src_valid (src_valid),
         .src_sel   (src_sel),
         .src_words (src_words),
         .valid     (valid),
         .sel       (sel),
         .words     (words)
      );
   end

   assign out_data  = g_lvl[SEL_W-1].words;
   assign out_valid = g_lvl[SEL_W-1].valid;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - self-checking bench for mux_tree_pipe (16x8, 2x1, 64x32)

module tb_mux_tree_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // DUT 0: 16 channels x 8 bits, depth 4
   logic [127:0]  a_data;
   logic [3:0]    a_sel;
   logic          a_valid, a_ready, a_ovalid, a_oready;
   logic [7:0]    a_odata;
   // DUT 1: 2 channels x 1 bit, depth 1
   logic [1:0]    b_data;
   logic          b_sel;
   logic          b_valid, b_ready, b_ovalid, b_oready;
   logic [0:0]    b_odata;
   // DUT 2: 64 channels x 32 bits, depth 6
   logic [2047:0] c_data;
   logic [5:0]    c_sel;
   logic          c_valid, c_ready, c_ovalid, c_oready;
   logic [31:0]   c_odata;

   mux_tree_pipe #(.DATA_W(8), .NUM_IN(16)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
      .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready));
   mux_tree_pipe #(.DATA_W(1), .NUM_IN(2)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
      .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready));
   mux_tree_pipe #(.DATA_W(32), .NUM_IN(64)) u_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
      .in_ready(c_ready), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_oready));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each accepted word is stamped with the count of pipe advances
   // seen so far; it must be at the output exactly when the advance count
   // reaches stamp + depth. Stalled cycles do not advance the count.
   logic [31:0] mq_data [3][$];
   int          mq_stamp[3][$];
   int          adv[3] = '{0, 0, 0};
   int          depth[3] = '{4, 1, 6};

   task automatic model_step(input int id, input logic ivld, input logic [31:0] isel_data,
                             input logic ordy, input logic ovld, input logic [31:0] odata,
                             input logic irdy);
      bit due;
      bit stall;
      if (!rst_n) begin
         mq_data[id].delete();
         mq_stamp[id].delete();
         chk($sformatf("dut%0d_rst_out_valid", id), {31'b0, ovld}, 32'd0);
         chk($sformatf("dut%0d_rst_out_data", id), odata, 32'd0);
         chk($sformatf("dut%0d_rst_in_ready", id), {31'b0, irdy}, 32'd1);
         return;
      end
      due = (mq_data[id].size() > 0) && (mq_stamp[id][0] + depth[id] == adv[id]);
      chk($sformatf("dut%0d_out_valid", id), {31'b0, ovld}, {31'b0, due});
      if (due) chk($sformatf("dut%0d_out_data", id), odata, mq_data[id][0]);
      stall = due && !ordy;
      chk($sformatf("dut%0d_in_ready", id), {31'b0, irdy}, {31'b0, !stall});
      if (!stall) begin
         if (due) begin
            void'(mq_data[id].pop_front());
            void'(mq_stamp[id].pop_front());
         end
         if (ivld) begin
            mq_data[id].push_back(isel_data);
            mq_stamp[id].push_back(adv[id]);
         end
         adv[id]++;
      end
   endtask

   // Inputs only change at posedge+1, so negedge sees what the next edge sees.
   always @(negedge clk) begin
      model_step(0, a_valid, {24'b0, a_data[a_sel*8 +: 8]}, a_oready, a_ovalid, {24'b0, a_odata}, a_ready);
      model_step(1, b_valid, {31'b0, b_data[b_sel]}, b_oready, b_ovalid, {31'b0, b_odata}, b_ready);
      model_step(2, c_valid, c_data[c_sel*32 +: 32], c_oready, c_ovalid, c_odata, c_ready);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a_ramp(input logic [7:0] base);
      for (int i = 0; i < 16; i++) a_data[i*8 +: 8] = base + 8'(i);
   endtask

   logic [3:0] seq4[4] = '{4'd0, 4'd15, 4'd7, 4'd8};
   logic       pat4[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic [3:0] psel[4] = '{4'd3, 4'd0, 4'd9, 4'd0};

   initial begin
      bit acc;
      int sent, got, stall_left;
      bit started;

      rst_n = 1'b0;
      a_data = '0; a_sel = '0; a_valid = 1'b0; a_oready = 1'b1;
      b_data = '0; b_sel = '0; b_valid = 1'b0; b_oready = 1'b1;
      c_data = '0; c_sel = '0; c_valid = 1'b0; c_oready = 1'b1;
      #1;
      chk("reset_out_valid", {31'b0, a_ovalid}, 32'd0);
      chk("reset_out_data", {24'b0, a_odata}, 32'd0);
      chk("reset_in_ready", {31'b0, a_ready}, 32'd1);
      repeat (3) cyc();

      // Single transfer, sel=5, channel i = 0x10+i; accepted on first edge after release.
      rst_n = 1'b1;
      set_a_ramp(8'h10);
      a_sel = 4'd5;
      a_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         a_valid = 1'b0;
         chk($sformatf("single_valid_e%0d", k), {31'b0, a_ovalid}, {31'b0, (k == 4)});
         if (k == 4) chk("single_data", {24'b0, a_odata}, 32'h15);
      end

      // Back-to-back 0,15,7,8 with channel i = i.
      set_a_ramp(8'h00);
      for (int c = 0; c < 8; c++) begin
         a_valid = (c < 4);
         a_sel = (c < 4) ? seq4[c] : 4'd0;
         cyc();
         chk($sformatf("b2b_valid_e%0d", c + 1), {31'b0, a_ovalid}, {31'b0, (c + 1 >= 4 && c + 1 <= 7)});
         if (c + 1 >= 4 && c + 1 <= 7) chk($sformatf("b2b_data_e%0d", c + 1), {24'b0, a_odata}, {28'b0, seq4[c - 3]});
      end

      // Alternating valid 1,0,1,0.
      for (int c = 0; c < 8; c++) begin
         a_valid = (c < 4) ? pat4[c] : 1'b0;
         a_sel = (c < 4) ? psel[c] : 4'd0;
         cyc();
         chk($sformatf("alt_valid_e%0d", c + 1), {31'b0, a_ovalid},
             {31'b0, (c + 1 >= 4 && c + 1 <= 7) ? pat4[c - 3] : 1'b0});
         chk($sformatf("alt_in_ready_e%0d", c + 1), {31'b0, a_ready}, 32'd1);
      end
      chk("alt_data_3", {24'b0, a_odata}, {24'b0, 8'h00});

      // Six transfers with a 3-cycle output stall once the first appears.
      set_a_ramp(8'hA0);
      sent = 0; got = 0; stall_left = 0; started = 0;
      for (int c = 0; c < 30 && got < 6; c++) begin
         a_valid = (sent < 6);
         a_sel = 4'(sent + 1);
         if (a_ovalid && !started) begin
            started = 1;
            stall_left = 3;
         end
         a_oready = (stall_left == 0);
         #1;
         if (stall_left > 0) begin
            chk("stall_in_ready", {31'b0, a_ready}, 32'd0);
            chk("stall_hold_data", {24'b0, a_odata}, 32'hA1);
            stall_left--;
         end
         acc = a_valid && a_ready;
         if (a_ovalid && a_oready) begin
            chk($sformatf("stall_order_%0d", got), {24'b0, a_odata}, 32'hA1 + 32'(got));
            got++;
         end
         cyc();
         if (acc) sent++;
      end
      a_valid = 1'b0;
      a_oready = 1'b1;
      chk("stall_count", 32'(got), 32'd6);
      repeat (6) cyc();

      // Reset with three transfers in flight, first just at the output.
      set_a_ramp(8'h00);
      for (int c = 0; c < 3; c++) begin
         a_valid = 1'b1;
         a_sel = 4'(2 + 2 * c);
         cyc();
      end
      a_valid = 1'b0;
      cyc();
      chk("pre_reset_valid", {31'b0, a_ovalid}, 32'd1);
      chk("pre_reset_data", {24'b0, a_odata}, 32'h02);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'b0, a_ovalid}, 32'd0);
      chk("midrst_out_data", {24'b0, a_odata}, 32'd0);
      chk("midrst_in_ready", {31'b0, a_ready}, 32'd1);
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("post_reset_no_stale", {31'b0, a_ovalid}, 32'd0);
      end

      // Literal latency pins for the two other geometries.
      b_data = 2'b10; b_sel = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 64; i++) c_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
      c_sel = 6'd63; c_valid = 1'b1;
      cyc();
      b_valid = 1'b0; c_valid = 1'b0;
      chk("n2_valid_lat1", {31'b0, b_ovalid}, 32'd1);
      chk("n2_data_lat1", {31'b0, b_odata}, 32'd1);
      repeat (4) cyc();
      chk("n64_valid_e5", {31'b0, c_ovalid}, 32'd0);
      cyc();
      chk("n64_valid_lat6", {31'b0, c_ovalid}, 32'd1);
      chk("n64_data_lat6", c_odata, 32'hC0DE_003F);
      cyc();

      // Random streams with random back-pressure; the model checks every cycle.
      for (int c = 0; c < 600; c++) begin
         a_valid = 1'($urandom_range(0, 1));
         a_sel = 4'($urandom_range(0, 15));
         for (int i = 0; i < 16; i++) a_data[i*8 +: 8] = 8'($urandom);
         a_oready = ($urandom_range(0, 3) != 0);
         b_valid = 1'($urandom_range(0, 1));
         b_sel = 1'($urandom_range(0, 1));
         b_data = 2'($urandom);
         b_oready = ($urandom_range(0, 2) != 0);
         c_valid = ($urandom_range(0, 3) != 0);
         c_sel = 6'($urandom_range(0, 63));
         for (int i = 0; i < 64; i++) c_data[i*32 +: 32] = $urandom;
         c_oready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      a_oready = 1'b1; b_oready = 1'b1; c_oready = 1'b1;
      repeat (10) cyc();
      chk("drain_a_empty", 32'(mq_data[0].size()), 32'd0);
      chk("drain_b_empty", 32'(mq_data[1].size()), 32'd0);
      chk("drain_c_empty", 32'(mq_data[2].size()), 32'd0);

      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_tree_pipe.md
MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 Parameter DATA_W, default 8: width in bits of each input channel and of the output.
REQ-002 Parameter NUM_IN, default 16: number of input channels; SHALL be a power of two, minimum 2, maximum 256.
REQ-003 Derived constant SEL_W = log2(NUM_IN): select width and number of tree levels.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  NUM_IN*DATA_W  packed channels; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 in_sel  input  SEL_W  binary channel index, sampled with in_data.
REQ-008 in_valid  input  1  in_data and in_sel are valid this cycle.
REQ-009 in_ready  output  1  the block accepts a transfer this cycle.
REQ-010 out_data  output  DATA_W  selected channel.
REQ-011 out_valid  output  1  out_data holds a result.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-013 The block SHALL be a binary tree of 2:1 selection levels, with level k (k = 0..SEL_W-1) driven by select bit k (LSB first), and each level registered.
REQ-014 Level k SHALL register NUM_IN>>(k+1) words, the unused select bits [SEL_W-1:k+1], and one valid bit.
REQ-015 Word j of level k SHALL equal word 2j+1 of the previous level when sel[k]=1, otherwise word 2j; level -1 is in_data.
REQ-016 out_data and out_valid SHALL be the word and valid bit of the final level, SEL_W-1.
REQ-017 Latency SHALL be exactly SEL_W cycles from an accepted input to out_valid with no stall.
REQ-018 Throughput SHALL be one transfer per cycle while out_ready=1.
REQ-019 Define stall = out_valid & ~out_ready; when stall=1, every level SHALL hold its contents, and in_ready=0.
REQ-020 in_ready SHALL equal ~stall; this is combinational from out_ready and out_valid.
REQ-021 A transfer SHALL occur when in_valid & in_ready; when in_ready=1 and in_valid=0, a bubble (valid=0) SHALL enter level 0.
REQ-022 Bubbles SHALL advance and collapse normally; a level holding valid=0 SHALL never cause a stall.
REQ-023 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 When stall=0, in_data and in_sel SHALL be ignored whenever in_valid=0, and the data registers MAY load, with the valid bit forced to 0.
REQ-025 in_sel values SHALL never be out of range, because NUM_IN is a power of two; no error output is defined.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately clear all valid bits, data words, and carried select bits to 0.
REQ-027 During reset, out_valid=0, out_data=0, and in_ready=1.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight transfers; none SHALL appear after release.
REQ-029 The first transfer SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package mux_tree_pkg SHALL hold the default DATA_W and NUM_IN, and a function clog2 used to derive SEL_W.
REQ-031 One sub-module, mux_level, SHALL implement a single registered level, parameterised by word count and carried-select width, with its own hold/enable input.
REQ-032 mux_tree_pipe SHALL instantiate SEL_W mux_level instances with a generate loop; there SHALL be no other logic apart from the stall/in_ready term.

Verification
REQ-033 Parameters 16/8, in_data with channel i = 8'h10+i, in_sel=5, out_ready=1 held → out_data=8'h15 and out_valid=1 exactly 4 cycles later, for one cycle.
REQ-034 Back-to-back sel 0,15,7,8 with channel i = i → outputs 0,15,7,8 on four consecutive cycles, starting at cycle 4.
REQ-035 Stream of 6 transfers with out_ready=0 for 3 cycles once out_valid=1 → out_data held stable, in_ready=0 during the stall, no loss or duplication, order preserved.
REQ-036 in_valid toggling 1,0,1,0 → out_valid pattern 1,0,1,0 delayed by 4 cycles, with no stall and no spurious output.
REQ-037 Reset pulsed with 3 transfers in flight → out_valid=0 and out_data=0 immediately, and no stale output after release.
REQ-038 Parameters NUM_IN=2, DATA_W=1 and NUM_IN=64, DATA_W=32 with a random sel/data stream and random out_ready → output matches the scoreboard model in_data[sel], with latency 1 and 6 respectively.
